// File: rtl/sram_arbiter_pkg.sv
// Purpose : shared types and constants for the single-port SRAM arbiter.
// Latency : n/a (types only).
// Backpress: n/a.
// Contents: FSM state enum, read-response owner enum, default widths, web helper.
package sram_arbiter_pkg;

  localparam int AW_DEF = 14;
  localparam int DW_DEF = 32;

  // Active-low byte enables with every lane deasserted mean "read".
  localparam logic [3:0] WEB_READ = 4'b1111;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_t;

  function automatic logic is_read(input logic [3:0] web);
    return web == WEB_READ;
  endfunction

endpackage

// File: rtl/rr_starve_pick.sv
// Purpose : picks IF or DM for the SRAM slot; DM wins unless IF has been denied STARVE_LIMIT times.
// Latency : combinational pick in the request cycle; starvation count updates on the clock edge.
// Backpress: en=0 blocks both picks (denied IF requests still count toward starvation).
// Ports   : clk, rst (async active-low), en, if_req, dm_req -> if_pick, dm_pick (one-hot or none).
module rr_starve_pick #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic if_req,
  input  logic dm_req,
  output logic if_pick,
  output logic dm_pick
);

  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] starve_cnt;
  logic          at_limit;

  assign at_limit = (starve_cnt == CW'(STARVE_LIMIT));

  // IF only wins over a competing DM request once it has starved long enough.
  assign if_pick = en && if_req && (at_limit || !dm_req);
  assign dm_pick = en && dm_req && !if_pick;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (if_req && !if_pick) begin
      if (!at_limit) starve_cnt <= starve_cnt + 1'b1;
    end else begin
      starve_cnt <= '0;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Purpose : shares one synchronous SRAM between CPU fetch (IF), CPU data (DM) and a bulk loader.
// Latency : grant in the request cycle; read data/rvalid one cycle after the grant.
// Backpress: requesters hold until gnt; loader waits for ld_ready while the CPU is held via cpu_hold.
// Ports   : clk, rst (async active-low); IF req/addr -> gnt/rvalid/rdata; DM req/web/addr/wdata ->
//           gnt/rvalid/rdata; loader ld_en/ld_we/ld_addr/ld_wdata -> ld_ready; cpu_hold;
//           SRAM_CS/OE/WEB/A/DI to the macro, SRAM_DO back from it.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int AW           = AW_DEF,
  parameter int DW           = DW_DEF,
  parameter int STARVE_LIMIT = 3
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,

  input  logic          dm_req,
  input  logic [3:0]    dm_web,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_rvalid,
  output logic [DW-1:0] dm_rdata,

  input  logic          ld_en,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  output logic          ld_ready,

  output logic          cpu_hold,

  output logic          SRAM_CS,
  output logic          SRAM_OE,
  output logic [3:0]    SRAM_WEB,
  output logic [AW-1:0] SRAM_A,
  output logic [DW-1:0] SRAM_DI,
  input  logic [DW-1:0] SRAM_DO
);

  state_t state;
  owner_t owner;
  logic   arb_en;
  logic   if_pick;
  logic   dm_pick;

  // CPU grants only happen in RUN, and not in the cycle the loader asks for the SRAM,
  // so DRAIN starts with at most one read still in flight. Reset gates grants directly
  // because they are combinational from the request inputs.
  assign arb_en = rst && (state == ST_RUN) && !ld_en;

  rr_starve_pick #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_pick (
    .clk    (clk),
    .rst    (rst),
    .en     (arb_en),
    .if_req (if_req),
    .dm_req (dm_req),
    .if_pick(if_pick),
    .dm_pick(dm_pick)
  );

  assign if_gnt = if_pick;
  assign dm_gnt = dm_pick;

  // Mode FSM; cpu_hold and ld_ready are registered alongside the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_RUN;
      cpu_hold <= 1'b0;
      ld_ready <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (ld_en) begin
            state    <= ST_DRAIN;
            cpu_hold <= 1'b1;
            ld_ready <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (ld_en) begin
            state    <= ST_LOAD;
            cpu_hold <= 1'b1;
            ld_ready <= 1'b1;
          end else begin
            state    <= ST_RUN;
            cpu_hold <= 1'b0;
            ld_ready <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (!ld_en) begin
            state    <= ST_RUN;
            cpu_hold <= 1'b0;
            ld_ready <= 1'b0;
          end
        end
        default: begin
          state    <= ST_RUN;
          cpu_hold <= 1'b0;
          ld_ready <= 1'b0;
        end
      endcase
    end
  end

  // Who gets SRAM_DO next cycle. Writes and idle cycles leave no owner, and the
  // async reset drops any read in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner <= OWN_NONE;
    end else if (if_gnt) begin
      owner <= OWN_IF;
    end else if (dm_gnt && is_read(dm_web)) begin
      owner <= OWN_DM;
    end else begin
      owner <= OWN_NONE;
    end
  end

  assign SRAM_OE   = (owner != OWN_NONE);
  assign if_rvalid = (owner == OWN_IF);
  assign dm_rvalid = (owner == OWN_DM);
  assign if_rdata  = (owner == OWN_IF) ? SRAM_DO : '0;
  assign dm_rdata  = (owner == OWN_DM) ? SRAM_DO : '0;

  // SRAM command mux. Loader writes are only possible in LOAD where no CPU grant exists.
  always_comb begin
    SRAM_CS  = 1'b0;
    SRAM_WEB = WEB_READ;
    SRAM_A   = '0;
    SRAM_DI  = '0;
    if ((state == ST_LOAD) && ld_we) begin
      SRAM_CS  = 1'b1;
      SRAM_WEB = 4'b0000;
      SRAM_A   = ld_addr;
      SRAM_DI  = ld_wdata;
    end else if (if_gnt) begin
      SRAM_CS  = 1'b1;
      SRAM_A   = if_addr;
    end else if (dm_gnt) begin
      SRAM_CS  = 1'b1;
      SRAM_WEB = dm_web;
      SRAM_A   = dm_addr;
      if (!is_read(dm_web)) SRAM_DI = dm_wdata;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;

  localparam int AW    = 14;
  localparam int DW    = 32;
  localparam int LIMIT = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt, if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          dm_req;
  logic [3:0]    dm_web;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_gnt, dm_rvalid;
  logic [DW-1:0] dm_rdata;
  logic          ld_en, ld_we;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_wdata;
  logic          ld_ready, cpu_hold;
  logic          SRAM_CS, SRAM_OE;
  logic [3:0]    SRAM_WEB;
  logic [AW-1:0] SRAM_A;
  logic [DW-1:0] SRAM_DI;
  logic [DW-1:0] SRAM_DO;

  always #5 clk = ~clk;

  sram_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_web(dm_web), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .ld_en(ld_en), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ready(ld_ready),
    .cpu_hold(cpu_hold),
    .SRAM_CS(SRAM_CS), .SRAM_OE(SRAM_OE), .SRAM_WEB(SRAM_WEB), .SRAM_A(SRAM_A),
    .SRAM_DI(SRAM_DI), .SRAM_DO(SRAM_DO)
  );

  // Behavioural synchronous SRAM driven from the DUT pins.
  logic [DW-1:0] mem [0:1023];
  always @(posedge clk) begin
    if (SRAM_CS) begin
      if (SRAM_WEB == 4'hF) SRAM_DO <= mem[SRAM_A[9:0]];
      else for (int b = 0; b < 4; b++)
        if (!SRAM_WEB[b]) mem[SRAM_A[9:0]][8*b +: 8] <= SRAM_DI[8*b +: 8];
    end
  end

  // Reference model: mode 0=run 1=drain 2=load; pend_own 0=none 1=IF 2=DM.
  int            checks = 0;
  int            failures = 0;
  int            mode, starve, pend_own;
  logic [DW-1:0] pend_data;
  logic [DW-1:0] ref_mem [0:1023];
  bit            e_if, e_dm;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mode = 0; starve = 0; pend_own = 0; e_if = 0; e_dm = 0;
  endtask

  task automatic check_reset();
    #1;
    check_eq("rst_if_gnt",    64'(if_gnt),    64'd0);
    check_eq("rst_dm_gnt",    64'(dm_gnt),    64'd0);
    check_eq("rst_if_rvalid", 64'(if_rvalid), 64'd0);
    check_eq("rst_dm_rvalid", 64'(dm_rvalid), 64'd0);
    check_eq("rst_ld_ready",  64'(ld_ready),  64'd0);
    check_eq("rst_cpu_hold",  64'(cpu_hold),  64'd0);
    check_eq("rst_cs",        64'(SRAM_CS),   64'd0);
    check_eq("rst_oe",        64'(SRAM_OE),   64'd0);
    check_eq("rst_web",       64'(SRAM_WEB),  64'hF);
    check_eq("rst_if_rdata",  64'(if_rdata),  64'd0);
    check_eq("rst_dm_rdata",  64'(dm_rdata),  64'd0);
    model_reset();
  endtask

  // Called right after inputs change at a negedge: checks this cycle, then advances the model.
  task automatic check_cycle();
    bit            can, e_cs, is_rd_gnt;
    logic [3:0]    e_web;
    logic [AW-1:0] e_a;
    logic [DW-1:0] e_di;
    #1;
    can  = (mode == 0) && !ld_en;
    e_if = can && if_req && (starve >= LIMIT || !dm_req);
    e_dm = can && dm_req && !e_if;
    e_cs = 0; e_web = 4'hF; e_a = '0; e_di = '0; is_rd_gnt = 0;
    if (mode == 2 && ld_we) begin
      e_cs = 1; e_web = 4'h0; e_a = ld_addr; e_di = ld_wdata;
    end else if (e_if) begin
      e_cs = 1; e_a = if_addr; is_rd_gnt = 1;
    end else if (e_dm) begin
      e_cs = 1; e_web = dm_web; e_a = dm_addr; e_di = dm_wdata;
      is_rd_gnt = (dm_web == 4'hF);
    end
    check_eq("if_gnt",    64'(if_gnt),    64'(e_if));
    check_eq("dm_gnt",    64'(dm_gnt),    64'(e_dm));
    check_eq("sram_cs",   64'(SRAM_CS),   64'(e_cs));
    check_eq("sram_web",  64'(SRAM_WEB),  64'(e_web));
    check_eq("sram_a",    64'(SRAM_A),    64'(e_a));
    if (!is_rd_gnt) check_eq("sram_di", 64'(SRAM_DI), 64'(e_di));
    check_eq("sram_oe",   64'(SRAM_OE),   64'(pend_own != 0));
    check_eq("if_rvalid", 64'(if_rvalid), 64'(pend_own == 1));
    check_eq("dm_rvalid", 64'(dm_rvalid), 64'(pend_own == 2));
    check_eq("if_rdata",  64'(if_rdata),  64'((pend_own == 1) ? pend_data : '0));
    check_eq("dm_rdata",  64'(dm_rdata),  64'((pend_own == 2) ? pend_data : '0));
    check_eq("cpu_hold",  64'(cpu_hold),  64'(mode != 0));
    check_eq("ld_ready",  64'(ld_ready),  64'(mode == 2));
    // advance model to the upcoming rising edge
    starve = (if_req && !e_if) ? ((starve < LIMIT) ? starve + 1 : LIMIT) : 0;
    pend_own = 0;
    if (e_if) begin
      pend_own = 1; pend_data = ref_mem[if_addr[9:0]];
    end else if (e_dm && dm_web == 4'hF) begin
      pend_own = 2; pend_data = ref_mem[dm_addr[9:0]];
    end
    if (e_dm && dm_web != 4'hF)
      for (int b = 0; b < 4; b++)
        if (!dm_web[b]) ref_mem[dm_addr[9:0]][8*b +: 8] = dm_wdata[8*b +: 8];
    if (mode == 2 && ld_we) ref_mem[ld_addr[9:0]] = ld_wdata;
    case (mode)
      0:       if (ld_en) mode = 1;
      1:       mode = ld_en ? 2 : 0;
      default: if (!ld_en) mode = 0;
    endcase
  endtask

  task automatic drive_idle();
    if_req = 0; dm_req = 0; dm_web = 4'hF; ld_en = 0; ld_we = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int ld_left;
    rst = 0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; ld_addr = '0; ld_wdata = '0;
    drive_idle();
    model_reset();
    pend_data = '0;
    repeat (2) @(negedge clk);
    check_reset();

    @(negedge clk); rst = 1; check_cycle();

    // Fill words 0..31 with full-word DM writes so every later read has a known value.
    for (int a = 0; a < 32; a++) begin
      @(negedge clk);
      dm_req = 1; dm_web = 4'b0000; dm_addr = AW'(a);
      dm_wdata = (a == 16) ? 32'hDEADBEEF : $urandom;
      check_cycle();
    end
    @(negedge clk); drive_idle(); check_cycle();

    // IF read alone: grant now, data next cycle.
    @(negedge clk); if_req = 1; if_addr = 14'h0010; check_cycle();
    check_eq("ifrd_gnt_c0", 64'(if_gnt), 64'd1);
    @(negedge clk); if_req = 0; check_cycle();
    check_eq("ifrd_rvalid_c1", 64'(if_rvalid), 64'd1);
    check_eq("ifrd_rdata_c1", 64'(if_rdata), 64'hDEADBEEF);

    // DM single-lane write.
    @(negedge clk); dm_req = 1; dm_web = 4'b1110; dm_addr = 14'h0003; dm_wdata = 32'h000000AA;
    check_cycle();
    check_eq("dmwr_gnt", 64'(dm_gnt), 64'd1);
    check_eq("dmwr_web", 64'(SRAM_WEB), 64'hE);
    check_eq("dmwr_a",   64'(SRAM_A), 64'h3);
    check_eq("dmwr_di",  64'(SRAM_DI), 64'hAA);
    @(negedge clk); drive_idle(); check_cycle();
    check_eq("dmwr_no_rvalid", 64'(dm_rvalid | if_rvalid), 64'd0);

    // Both requesting continuously: DM,DM,DM,IF repeating.
    @(negedge clk); if_req = 1; if_addr = 14'd6; dm_req = 1; dm_web = 4'hF; dm_addr = 14'd5;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      check_cycle();
      check_eq("seq_if", 64'(if_gnt), 64'(i % 4 == 3));
      check_eq("seq_dm", 64'(dm_gnt), 64'(i % 4 != 3));
    end
    @(negedge clk); drive_idle(); check_cycle();

    // DM read, then loader arrives together with an IF request.
    @(negedge clk); dm_req = 1; dm_web = 4'hF; dm_addr = 14'd7; check_cycle();
    check_eq("drain_dm_gnt", 64'(dm_gnt), 64'd1);
    @(negedge clk); dm_req = 0; ld_en = 1; if_req = 1; if_addr = 14'd9; check_cycle();
    check_eq("drain_dm_rvalid", 64'(dm_rvalid), 64'd1);
    check_eq("ld_en_blocks_if", 64'(if_gnt), 64'd0);
    @(negedge clk); check_cycle();
    check_eq("drain_hold", 64'(cpu_hold), 64'd1);
    check_eq("drain_not_ready", 64'(ld_ready), 64'd0);
    @(negedge clk); ld_we = 1; ld_addr = 14'h0100; ld_wdata = 32'h1234; check_cycle();
    check_eq("load_ready", 64'(ld_ready), 64'd1);
    check_eq("load_hold",  64'(cpu_hold), 64'd1);
    check_eq("load_cs",    64'(SRAM_CS), 64'd1);
    check_eq("load_web",   64'(SRAM_WEB), 64'h0);
    check_eq("load_a",     64'(SRAM_A), 64'h100);
    check_eq("load_di",    64'(SRAM_DI), 64'h1234);
    @(negedge clk); ld_en = 0; ld_we = 0; check_cycle();
    @(negedge clk); check_cycle();
    check_eq("run_hold_low", 64'(cpu_hold), 64'd0);
    check_eq("run_if_gnt",   64'(if_gnt), 64'd1);
    @(negedge clk); drive_idle(); check_cycle();

    // Reset in the middle of a read.
    @(negedge clk); dm_req = 1; dm_web = 4'hF; dm_addr = 14'd8; check_cycle();
    @(negedge clk); rst = 0; check_reset();
    repeat (2) @(negedge clk);
    drive_idle(); rst = 1; check_cycle();
    check_eq("post_rst_no_rvalid", 64'(dm_rvalid | if_rvalid), 64'd0);

    // Randomised traffic with a protocol-respecting requester and loader.
    ld_left = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (e_if) if_req = 0;
      if (e_dm) dm_req = 0;
      if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1; if_addr = AW'($urandom_range(0, 31));
      end
      if (!dm_req && $urandom_range(0, 2) == 0) begin
        dm_req = 1; dm_addr = AW'($urandom_range(0, 31)); dm_wdata = $urandom;
        case ($urandom_range(0, 3))
          0, 1:    dm_web = 4'hF;
          2:       dm_web = 4'h0;
          default: dm_web = 4'($urandom);
        endcase
      end
      if (ld_left > 0) ld_left--;
      else if (ld_en) ld_en = 0;
      else if ($urandom_range(0, 40) == 0) begin
        ld_en = 1; ld_left = $urandom_range(0, 6);
      end
      ld_we = 1'($urandom_range(0, 1));
      ld_addr = AW'($urandom_range(0, 31));
      ld_wdata = $urandom;
      check_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameters (name, default, meaning): AW, 14, word-address width; DW, 32, data width; STARVE_LIMIT, 3, consecutive IF denials before IF gets priority.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 if_req  in  1  instruction-fetch read request; if_addr  in  AW  fetch word address.
REQ-005 if_gnt  out  1  IF granted this cycle; if_rvalid  out  1  IF read data valid; if_rdata  out  DW  IF read data.
REQ-006 dm_req  in  1  data request; dm_web  in  4  active-low byte write enables (4'b1111 = read); dm_addr  in  AW; dm_wdata  in  DW.
REQ-007 dm_gnt  out  1  DM granted; dm_rvalid  out  1  DM read data valid; dm_rdata  out  DW.
REQ-008 ld_en  in  1  loader mode request; ld_we  in  1  loader word write strobe; ld_addr  in  AW; ld_wdata  in  DW; ld_ready  out  1  loader owns SRAM.
REQ-009 cpu_hold  out  1  stall to the CPU pipeline while not in RUN.
REQ-010 SRAM_CS  out  1; SRAM_OE  out  1; SRAM_WEB  out  4 (active-low); SRAM_A  out  AW; SRAM_DI  out  DW; SRAM_DO  in  DW (valid the cycle after the address).

Function
REQ-011 FSM states RUN, DRAIN, LOAD; reset state RUN.
REQ-012 RUN->DRAIN when ld_en=1; DRAIN->LOAD the following cycle (one outstanding read completes); LOAD->RUN when ld_en=0; DRAIN->RUN if ld_en drops during DRAIN.
REQ-013 RUN arbitration, combinational same cycle: at most one of if_gnt/dm_gnt high; default DM beats IF.
REQ-014 Starvation counter: increments when if_req=1 and if_gnt=0, clears on if_gnt or if_req=0, saturates at STARVE_LIMIT; at STARVE_LIMIT IF beats DM.
REQ-015 Requester holds req/addr/data stable until gnt; gnt is a one-cycle acknowledge of that access.
REQ-016 On a grant: SRAM_CS=1, SRAM_A=winner address; DM write drives SRAM_WEB=dm_web and SRAM_DI=dm_wdata; reads drive SRAM_WEB=4'b1111.
REQ-017 Read grant registers the response owner; next cycle SRAM_OE=1 and owner rvalid=1 for exactly one cycle; rdata = SRAM_DO routed to the owner; non-owner rdata = 0.
REQ-018 No grant: SRAM_CS=0, SRAM_WEB=4'b1111, SRAM_A/SRAM_DI hold 0.
REQ-019 DRAIN: no new grants; the outstanding response still delivers; cpu_hold=1.
REQ-020 LOAD: ld_ready=1, cpu_hold=1, if_gnt=dm_gnt=0; ld_we=1 -> SRAM_CS=1, SRAM_WEB=4'b0000, SRAM_A=ld_addr, SRAM_DI=ld_wdata; ld_we=0 -> idle SRAM.
REQ-021 Simultaneous ld_en and CPU request in RUN: the CPU request is not granted in that cycle; the state moves to DRAIN.
REQ-022 dm_web with all bits low and a single low bit are both legal; the block does not decode byte lanes.

Reset
REQ-023 rst=0 asynchronously forces: state RUN, starvation counter 0, response owner none, all gnt/rvalid/ld_ready/cpu_hold/SRAM_CS/SRAM_OE=0, SRAM_WEB=4'b1111, rdata=0.
REQ-024 A read in flight at reset assertion is discarded; no rvalid is produced after reset release.

Structure
REQ-025 The shared package holds the state enum (RUN/DRAIN/LOAD), the response-owner enum (NONE/IF/DM) and the AW/DW constants.
REQ-026 The priority/starvation logic is one sub-module, rr_starve_pick; the FSM and SRAM muxing stay in the top.

Verification
REQ-027 if_req only, addr 0x0010, SRAM_DO=0xDEADBEEF -> if_gnt cycle 0; if_rvalid=1 and if_rdata=0xDEADBEEF at cycle 1.
REQ-028 DM write, dm_web=4'b1110, addr 0x0003, data 0x000000AA -> dm_gnt=1, SRAM_WEB=4'b1110, SRAM_A=0x0003, SRAM_DI=0xAA in the same cycle; no rvalid.
REQ-029 if_req and dm_req both held continuously -> grant sequence DM,DM,DM,IF, repeating.
REQ-030 ld_en rises the cycle after a DM read grant -> dm_rvalid still fires; DRAIN for 1 cycle; then ld_ready=1 and cpu_hold=1; ld_we writes 0x1234 to 0x0100 with SRAM_WEB=4'b0000.
REQ-031 ld_en drops -> RUN next cycle; cpu_hold=0; a pending if_req is granted.
REQ-032 rst pulsed low mid-read -> all outputs take reset values immediately; no rvalid after release.
